// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: state enum,
// opcode/funct fields, alu_op codes and alu_control codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_CTL_AND = 3'b000;
  localparam logic [2:0] ALU_CTL_OR  = 3'b001;
  localparam logic [2:0] ALU_CTL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTL_SUB = 3'b110;
  localparam logic [2:0] ALU_CTL_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Purely combinational ALU control decode from the FSM's alu_op and the
// R-type funct field.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_CTL_ADD;
    if (alu_op[1]) begin
      // Unknown funct codes fall back to add.
      case (funct)
        FUNCT_ADD: alu_control = ALU_CTL_ADD;
        FUNCT_SUB: alu_control = ALU_CTL_SUB;
        FUNCT_AND: alu_control = ALU_CTL_AND;
        FUNCT_OR:  alu_control = ALU_CTL_OR;
        FUNCT_SLT: alu_control = ALU_CTL_SLT;
        default:   alu_control = ALU_CTL_ADD;
      endcase
    end else if (alu_op[0]) begin
      alu_control = ALU_CTL_SUB;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j).
// Define MC_JUMP_EN to decode j into the JUMP state; otherwise j is a no-op.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  // Memory handshake: a memory state holds its address/strobe outputs every
  // cycle and leaves only on a cycle where mem_ready=1 (data valid or write
  // accepted); there is no separate request/valid from this side.

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;
  logic       unencoded;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    alu_op    = ALU_OP_ADD;
    unencoded = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALU_OP_SUB;
        PCSrc   = 2'b01;
        PCEn    = zero_flag;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
`endif
      default: begin
        unencoded = 1'b1;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_dec)
  );

  // Unencoded states must present an all-zero output word, including ALU control.
  assign alu_control = unencoded ? 3'b000 : alu_dec;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle stimulus and expected
// state/output words are queued, then replayed and compared cycle by cycle.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic       PCEn;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] alu_control;
  logic [3:0] state;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct       (funct),
    .zero_flag   (zero_flag),
    .mem_ready   (mem_ready),
    .PCEn        (PCEn),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSrc       (PCSrc),
    .alu_control (alu_control),
    .state       (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: PCEn IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB PCSrc alu_control
  logic [14:0] dut_o;
  assign dut_o = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSrc, alu_control};

  // Hand-numbered state encodings
  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                         ST_EXEC = 4'd6, ST_ALUWB = 4'd7, ST_BRANCH = 4'd8,
                         ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  // entry: {mem_ready, zero_flag, exp_state[3:0], exp_out[14:0]}
  logic [20:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] ov(input logic pcen, input logic iord, input logic mw,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] aluc);
    return {pcen, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, aluc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic rdy, input logic zf, input logic [3:0] st, input logic [14:0] o);
    exp_q.push_back({rdy, zf, st, o});
  endtask

  task automatic run_q(input string tag);
    logic [20:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = e[20];
      zero_flag = e[19];
      #1;
      check($sformatf("%s[%0d].state", tag, n), {28'd0, state}, {28'd0, e[18:15]});
      check($sformatf("%s[%0d].out", tag, n), {17'd0, dut_o}, {17'd0, e[14:0]});
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check($sformatf("%s.state", tag), {28'd0, state}, 32'd0);
    check($sformatf("%s.MemWrite", tag), {31'd0, MemWrite}, 32'd0);
  endtask

  logic [14:0] o_f0, o_f1, o_dec, o_madr, o_mrd, o_mwb, o_mwr, o_aluwb;
  logic [14:0] o_br1, o_br0, o_addiex, o_addiwb, o_jump;

  // ---------------- stimulus ----------------
  initial begin
    o_f0     = ov(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010);
    o_f1     = ov(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010);
    o_dec    = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
    o_madr   = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
    o_mrd    = ov(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010);
    o_mwb    = ov(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010);
    o_mwr    = ov(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010);
    o_aluwb  = ov(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010);
    o_br1    = ov(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
    o_br0    = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
    o_addiex = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
    o_addiwb = ov(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010);
    o_jump   = ov(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010);

    rst = 1'b1; mem_ready = 1'b0; zero_flag = 1'b0; op = 6'b0; funct = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.state", {28'd0, state}, 32'd0);
    check("reset.out", {17'd0, dut_o}, {17'd0, o_f0});
    push(0,0,ST_FETCH,o_f0); push(0,0,ST_FETCH,o_f0); push(0,0,ST_FETCH,o_f0);
    run_q("idle");

    // lw, zero wait states: 5 cycles
    op = 6'b100011;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_MEMADR,o_madr);
    push(1,0,ST_MEMRD,o_mrd); push(1,0,ST_MEMWB,o_mwb); push(0,0,ST_FETCH,o_f0);
    run_q("lw");

    // lw with one wait cycle in MEMRD
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_MEMADR,o_madr);
    push(0,0,ST_MEMRD,o_mrd); push(1,0,ST_MEMRD,o_mrd); push(1,0,ST_MEMWB,o_mwb);
    push(0,0,ST_FETCH,o_f0);
    run_q("lw_wait");

    // sw: 3 wait cycles in MEMWR, MemWrite held 4 cycles
    op = 6'b101011;
    push(1,0,ST_FETCH,o_f1); push(0,0,ST_DECODE,o_dec); push(0,0,ST_MEMADR,o_madr);
    push(0,0,ST_MEMWR,o_mwr); push(0,0,ST_MEMWR,o_mwr); push(0,0,ST_MEMWR,o_mwr);
    push(1,0,ST_MEMWR,o_mwr); push(0,0,ST_FETCH,o_f0);
    run_q("sw");

    // beq taken then not taken
    op = 6'b000100;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,1,ST_BRANCH,o_br1);
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_BRANCH,o_br0);
    push(0,0,ST_FETCH,o_f0);
    run_q("beq");

    // R-type slt, sub, or, unknown funct
    op = 6'b000000; funct = 6'b101010;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    push(1,0,ST_EXEC,ov(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111)); push(1,0,ST_ALUWB,o_aluwb);
    run_q("slt");
    funct = 6'b100010;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    push(1,0,ST_EXEC,ov(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110)); push(1,0,ST_ALUWB,o_aluwb);
    run_q("sub");
    funct = 6'b100101;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    push(1,0,ST_EXEC,ov(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001)); push(1,0,ST_ALUWB,o_aluwb);
    run_q("or");
    funct = 6'b100100;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    push(1,0,ST_EXEC,ov(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000)); push(1,0,ST_ALUWB,o_aluwb);
    run_q("and");
    funct = 6'b111111;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    push(1,0,ST_EXEC,ov(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010)); push(1,0,ST_ALUWB,o_aluwb);
    run_q("funct_other");

    // unknown opcode: DECODE straight back to FETCH
    op = 6'b111111;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(0,0,ST_FETCH,o_f0);
    run_q("bad_op");

    // addi
    op = 6'b001000;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_ADDIEX,o_addiex);
    push(1,0,ST_ADDIWB,o_addiwb); push(0,0,ST_FETCH,o_f0);
    run_q("addi");

    // j
    op = 6'b000010;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
`ifdef MC_JUMP_EN
    push(1,0,ST_JUMP,o_jump);
`else
    push(0,0,ST_FETCH,o_f0);
`endif
    push(0,0,ST_FETCH,o_f0);
    run_q("j");

    // reset in the middle of MEMWR and of MEMRD
    op = 6'b101011;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_MEMADR,o_madr);
    push(0,0,ST_MEMWR,o_mwr); push(0,0,ST_MEMWR,o_mwr);
    run_q("sw_pre_rst");
    reset_now("rst_memwr");
    push(0,0,ST_FETCH,o_f0);
    run_q("post_rst_memwr");
    op = 6'b100011;
    push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec); push(1,0,ST_MEMADR,o_madr);
    push(0,0,ST_MEMRD,o_mrd);
    run_q("lw_pre_rst");
    reset_now("rst_memrd");
    push(0,0,ST_FETCH,o_f0); push(1,0,ST_FETCH,o_f1); push(1,0,ST_DECODE,o_dec);
    run_q("post_rst_memrd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock of the block.
REQ-002 rst  in  1  reset; synchronous and active-high.
REQ-003 op  in  6  opcode from the instruction register; stable from DECODE until the next FETCH.
REQ-004 funct  in  6  R-type function field from the instruction register.
REQ-005 zero_flag  in  1  ALU zero result; sampled combinationally in BRANCH.
REQ-006 mem_ready  in  1  unified memory handshake; 1 = read data valid or write accepted this cycle.
REQ-007 PCEn  out  1  PC register load enable.
REQ-008 IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  out  1  memory write strobe.
REQ-010 IRWrite  out  1  instruction register load enable.
REQ-011 RegDst  out  1  write register select: 0 = rt, 1 = rd.
REQ-012 MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = memory data.
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 ALUSrcA  out  1  ALU A: 0 = PC, 1 = register A.
REQ-015 ALUSrcB  out  2  ALU B: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-016 PCSrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 alu_control  out  3  010 add, 110 sub, 000 AND, 001 OR, 111 slt.
REQ-018 state  out  4  current state encoding; for debug and verification only.

Function
REQ-019 The block SHALL be a Moore FSM with a 4-bit state register. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-020 Every output not listed for a state SHALL be 0. All outputs SHALL be combinational from state, plus mem_ready and zero_flag where stated.
REQ-021 FETCH: ALUSrcB=01, alu_op=00. IRWrite and PCEn SHALL equal mem_ready. Go to DECODE when mem_ready=1; otherwise stay in FETCH.
REQ-022 DECODE: ALUSrcB=11, alu_op=00. Next state by op:
- lw 100011 or sw 101011 -> MEMADR
- 000000 -> EXECUTE
- beq 000100 -> BRANCH
- addi 001000 -> ADDIEXEC
- j 000010 -> JUMP
- any other op -> FETCH
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: IorD=1. Stay until mem_ready=1, then go to MEMWB.
REQ-025 MEMWB: MemtoReg=1, RegWrite=1 for exactly one cycle, then FETCH.
REQ-026 MEMWR: IorD=1, MemWrite=1. Hold both until mem_ready=1, then FETCH.
REQ-027 EXECUTE: ALUSrcA=1, ALUSrcB=00, alu_op=10, then ALUWB.
REQ-028 ALUWB: RegDst=1, RegWrite=1, then FETCH.
REQ-029 BRANCH: ALUSrcA=1, alu_op=01, PCSrc=01, PCEn=zero_flag, then FETCH.
REQ-030 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, alu_op=00, then ADDIWB. ADDIWB: RegWrite=1, then FETCH.
REQ-031 JUMP: PCSrc=10, PCEn=1, then FETCH.
REQ-032 ALU decode:
- alu_op 00 -> 010; 01 -> 110.
- alu_op 1x by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
REQ-033 Unencoded states 12-15 SHALL drive all outputs 0 and return to FETCH on the next edge.
REQ-034 Latency in cycles, with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-035 With rst=1 at a clock edge, the state SHALL become FETCH regardless of the current state, including mid-MEMWR or MEMRD.
REQ-036 After reset, all outputs SHALL be 0 except ALUSrcB=01 and alu_control=010, until mem_ready=1.

Configuration
REQ-037 Macro MC_JUMP_EN:
- Defined: j is decoded to JUMP and state 11 exists.
- Undefined: op 000010 goes from DECODE to FETCH, state 11 is treated as unencoded, and PCSrc never equals 10.

Structure
REQ-038 Package mips_pkg SHALL hold the state enum, opcode constants, funct constants, alu_op codes and alu_control codes.
REQ-039 Sub-module alu_decoder (alu_op, funct -> alu_control) SHALL be purely combinational and instantiated once.

Verification
REQ-040 rst=1 for 2 cycles, mem_ready=0 -> state=0, IRWrite=0, PCEn=0, ALUSrcB=01, stays in FETCH.
REQ-041 lw with mem_ready held 1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-042 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-043 beq with zero_flag=1, then again with zero_flag=0 -> PCEn=1 in BRANCH for the first case only; PCSrc=01, alu_control=110 in both.
REQ-044 R-type funct 101010 -> alu_control=111 in EXECUTE; RegDst=1, RegWrite=1 in ALUWB. Then op=111111 -> DECODE to FETCH with no writes.
REQ-045 rst asserted in MEMWR -> state=0 and MemWrite=0 after the edge. j with MC_JUMP_EN undefined -> DECODE to FETCH, PCEn=0.
